// File: rtl/pipe_pkg.sv
// Shared constants for the in-order pipeline stall/flush controller.
// Latency: none (constants only).
// Backpressure: not applicable.
package pipe_pkg;

    // Pipeline register indices (register k sits between stage k and k+1)
    localparam int ST_IF  = 0;   // PC/IF
    localparam int ST_ID  = 1;   // IF/ID
    localparam int ST_EXE = 2;   // ID/EXE
    localparam int ST_MEM = 3;   // EXE/MEM
    localparam int ST_WB  = 4;   // MEM/WB

    // Stall source indices into stall_req
    localparam int SRC_DIV  = 0;
    localparam int SRC_MUL  = 1;
    localparam int SRC_JALR = 2;
    localparam int SRC_CSR  = 3;

    // 3 bits per source; source i occupies bits [3*i +: 3].
    // Each source stalls registers 0..depth-1.
    localparam int          SRC_DEPTH_BITS = 3;
    localparam logic [11:0] SRC_DEPTH_DFLT = {3'd3, 3'd3, 3'd2, 3'd2};

endpackage

// File: rtl/pipe_load_stall_cnt.sv
// Load-use hazard qualification and multi-cycle load stall counter.
// Latency: load_stall_active is combinational (same cycle as load_hazard).
// Backpressure: none; a hazard seen while the counter runs is dropped.
//
// Ports: clk, rst (sync, active-high), load_hazard (raw hazard),
//        prod_bubble (producer register holds a bubble),
//        load_stall_active (stall the load-covered stages this cycle).
module pipe_load_stall_cnt #(
    parameter int LOAD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load_hazard,
    input  logic prod_bubble,
    output logic load_stall_active
);

    logic [3:0] lcnt;
    logic       ld;

    // A bubble cannot produce a load result, and an active count is never
    // reloaded, so the total stall is exactly LOAD_LAT cycles.
    assign ld                = load_hazard & ~prod_bubble & (lcnt == 4'd0);
    assign load_stall_active = ld | (lcnt != 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            lcnt <= 4'd0;
        end else if (ld) begin
            lcnt <= 4'(LOAD_LAT - 1);
        end else if (lcnt != 4'd0) begin
            lcnt <= lcnt - 4'd1;
        end
    end

endmodule

// File: rtl/pipe_sf_ctrl.sv
// Stall/flush/clock-enable controller for an N-stage in-order pipeline.
// Latency: all outputs combinational except bubble/stall_timeout (1 cycle).
// Backpressure: none accepted; stall outputs are the pipeline backpressure.
//
// Ports: clk, rst (sync, active-high); stall_req/load_hazard/flush_req
// requests; if_pc/id_pc/is_jump for self-loop jump gating; wb_wr_en;
// outputs stall, flush, clk_en per register, rf_clk_en, bubble,
// load_stall_active, stall_timeout.
// Optional: define STALL_WDOG_EN to add the stall watchdog behind
// stall_timeout (tied low otherwise).
module pipe_sf_ctrl
    import pipe_pkg::*;
#(
    parameter int                  NUM_STAGES = 5,
    parameter int                  NUM_SRC    = 4,
    parameter logic [NUM_SRC*3-1:0] SRC_DEPTH = SRC_DEPTH_DFLT,
    parameter int                  LOAD_DEPTH = 3,
    parameter int                  LOAD_LAT   = 1,
    parameter int                  PC_W       = 12,
    parameter int                  WDOG_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_SRC-1:0]    stall_req,
    input  logic                  load_hazard,
    input  logic [NUM_STAGES-1:0] flush_req,
    input  logic [PC_W-1:0]       if_pc,
    input  logic [PC_W-1:0]       id_pc,
    input  logic                  is_jump,
    input  logic                  wb_wr_en,
    output logic [NUM_STAGES-1:0] stall,
    output logic [NUM_STAGES-1:0] flush,
    output logic [NUM_STAGES-1:0] clk_en,
    output logic                  rf_clk_en,
    output logic [NUM_STAGES-1:0] bubble,
    output logic                  load_stall_active,
    output logic                  stall_timeout
);

    logic [NUM_STAGES-1:0] bubble_q;
    logic [NUM_STAGES-1:0] stall_c;
    logic [NUM_STAGES-1:0] inj_c;
    logic [NUM_STAGES-1:0] flush_c;
    logic [NUM_STAGES-1:0] clk_en_c;
    logic                  lstall;
    logic                  loop_c;

    pipe_load_stall_cnt #(
        .LOAD_LAT (LOAD_LAT)
    ) u_ld_cnt (
        .clk               (clk),
        .rst               (rst),
        .load_hazard       (load_hazard),
        .prod_bubble       (bubble_q[LOAD_DEPTH]),
        .load_stall_active (lstall)
    );

    // Each source stalls a contiguous prefix of registers, so the OR of
    // prefixes is itself a prefix: stall[k] implies stall[k-1].
    always_comb begin
        stall_c = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (int'(SRC_DEPTH[i*SRC_DEPTH_BITS +: SRC_DEPTH_BITS]) > k) begin
                    stall_c[k] = stall_c[k] | stall_req[i];
                end
            end
            if (k < LOAD_DEPTH) begin
                stall_c[k] = stall_c[k] | lstall;
            end
        end
    end

    // A jump to itself would refetch forever; freeze IF and feed ID a bubble.
    assign loop_c = (if_pc == id_pc) & is_jump & ~stall_c[ST_ID];

    // The first register past a stall boundary must not re-consume the
    // held instruction, so it is cleared into a bubble.
    always_comb begin
        inj_c = '0;
        for (int k = 1; k < NUM_STAGES; k++) begin
            inj_c[k] = stall_c[k-1] & ~stall_c[k];
        end
        inj_c[ST_ID] = inj_c[ST_ID] | loop_c;
    end

    assign flush_c = flush_req | inj_c;

    // A flushed register still needs its clock to load the cleared value.
    always_comb begin
        clk_en_c        = '0;
        clk_en_c[ST_IF] = ~(stall_c[ST_IF] | loop_c);
        clk_en_c[ST_ID] = ~(stall_c[ST_ID] | bubble_q[ST_IF] | loop_c);
        for (int k = 2; k < NUM_STAGES; k++) begin
            clk_en_c[k] = ~(stall_c[k] | bubble_q[k-1]) | flush_c[k];
        end
    end

    // Bubble tracking: a stalled register keeps its marker, otherwise the
    // marker advances from the register below.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_q <= '0;
        end else begin
            bubble_q[ST_IF] <= flush_c[ST_IF] | (stall_c[ST_IF] & bubble_q[ST_IF]);
            for (int k = 1; k < NUM_STAGES; k++) begin
                bubble_q[k] <= flush_c[k] | inj_c[k] |
                               (stall_c[k] ? bubble_q[k] : bubble_q[k-1]);
            end
        end
    end

    assign stall             = rst ? '0 : stall_c;
    assign flush             = rst ? '1 : flush_c;
    assign clk_en            = rst ? '1 : clk_en_c;
    assign rf_clk_en         = ~rst & wb_wr_en & ~bubble_q[NUM_STAGES-1];
    assign bubble            = bubble_q;
    assign load_stall_active = lstall;

`ifdef STALL_WDOG_EN
    logic [WDOG_W-1:0] wdog_cnt;
    logic [WDOG_W-1:0] wdog_nxt;
    logic              wdog_trip;

    // Saturating count of consecutive IF stall cycles.
    always_comb begin
        wdog_nxt = '0;
        if (stall_c[ST_IF]) begin
            wdog_nxt = (wdog_cnt == '1) ? wdog_cnt : wdog_cnt + 1'b1;
        end
    end

    // Trip lands on the same edge the counter reaches all-ones; sticky.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt  <= '0;
            wdog_trip <= 1'b0;
        end else begin
            wdog_cnt  <= wdog_nxt;
            wdog_trip <= wdog_trip | (wdog_nxt == '1);
        end
    end

    assign stall_timeout = ~rst & wdog_trip;
`else
    // No watchdog: constant low for any legal WDOG_W.
    assign stall_timeout = (WDOG_W < 1);
`endif

endmodule

// File: tb/tb_pipe_sf_ctrl.sv
// Directed bench for pipe_sf_ctrl with a queued-expectation scoreboard.
// Two DUTs share inputs: dut (LOAD_LAT=1) and dut3 (LOAD_LAT=3).
// Source depths here: src0=3, src1=3, src2=2, src3=2.
module tb_pipe_sf_ctrl;

    localparam logic [11:0] TB_DEPTH = {3'd2, 3'd2, 3'd3, 3'd3};

    localparam int S_STALL  = 0;
    localparam int S_FLUSH  = 1;
    localparam int S_CLKEN  = 2;
    localparam int S_BUB    = 3;
    localparam int S_RF     = 4;
    localparam int S_LSA    = 5;
    localparam int S_TO     = 6;
    localparam int S_STALL3 = 7;
    localparam int S_LSA3   = 8;

    logic        clk;
    logic        rst;
    logic [3:0]  stall_req;
    logic        load_hazard;
    logic [4:0]  flush_req;
    logic [11:0] if_pc;
    logic [11:0] id_pc;
    logic        is_jump;
    logic        wb_wr_en;

    logic [4:0]  stall, flush, clk_en, bubble;
    logic        rf_clk_en, load_stall_active, stall_timeout;
    logic [4:0]  stall3, flush3, clk_en3, bubble3;
    logic        rf_clk_en3, load_stall_active3, stall_timeout3;

    int checks = 0;
    int errors = 0;

    string      q_name[$];
    int         q_sig[$];
    logic [4:0] q_val[$];

    pipe_sf_ctrl #(
        .NUM_STAGES (5), .NUM_SRC (4), .SRC_DEPTH (TB_DEPTH),
        .LOAD_DEPTH (3), .LOAD_LAT (1), .PC_W (12), .WDOG_W (4)
    ) dut (
        .clk (clk), .rst (rst), .stall_req (stall_req), .load_hazard (load_hazard),
        .flush_req (flush_req), .if_pc (if_pc), .id_pc (id_pc), .is_jump (is_jump),
        .wb_wr_en (wb_wr_en), .stall (stall), .flush (flush), .clk_en (clk_en),
        .rf_clk_en (rf_clk_en), .bubble (bubble),
        .load_stall_active (load_stall_active), .stall_timeout (stall_timeout)
    );

    pipe_sf_ctrl #(
        .NUM_STAGES (5), .NUM_SRC (4), .SRC_DEPTH (TB_DEPTH),
        .LOAD_DEPTH (3), .LOAD_LAT (3), .PC_W (12), .WDOG_W (4)
    ) dut3 (
        .clk (clk), .rst (rst), .stall_req (stall_req), .load_hazard (load_hazard),
        .flush_req (flush_req), .if_pc (if_pc), .id_pc (id_pc), .is_jump (is_jump),
        .wb_wr_en (wb_wr_en), .stall (stall3), .flush (flush3), .clk_en (clk_en3),
        .rf_clk_en (rf_clk_en3), .bubble (bubble3),
        .load_stall_active (load_stall_active3), .stall_timeout (stall_timeout3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] sample(input int sig);
        case (sig)
            S_STALL:  return stall;
            S_FLUSH:  return flush;
            S_CLKEN:  return clk_en;
            S_BUB:    return bubble;
            S_RF:     return {4'b0, rf_clk_en};
            S_LSA:    return {4'b0, load_stall_active};
            S_TO:     return {4'b0, stall_timeout};
            S_STALL3: return stall3;
            S_LSA3:   return {4'b0, load_stall_active3};
            default:  return 5'bx;
        endcase
    endfunction

    // Monitor: every negedge the DUT outputs for the current cycle are
    // compared against whatever the stimulus queued for that cycle.
    string      m_name;
    int         m_sig;
    logic [4:0] m_exp, m_act;
    always @(negedge clk) begin
        while (q_sig.size() > 0) begin
            m_name = q_name.pop_front();
            m_sig  = q_sig.pop_front();
            m_exp  = q_val.pop_front();
            m_act  = sample(m_sig);
            checks++;
            if (m_act !== m_exp) begin
                errors++;
                $display("FAIL %s: got %b expected %b at %0t", m_name, m_act, m_exp, $time);
            end
        end
    end

    task automatic exp_sig(input string name, input int sig, input logic [4:0] val);
        q_name.push_back(name);
        q_sig.push_back(sig);
        q_val.push_back(val);
    endtask

    // Advance to just after the next rising edge and return inputs to idle.
    task automatic next();
        @(posedge clk);
        #1;
        rst         = 1'b0;
        stall_req   = 4'b0;
        load_hazard = 1'b0;
        flush_req   = 5'b0;
        if_pc       = 12'h000;
        id_pc       = 12'h004;
        is_jump     = 1'b0;
        wb_wr_en    = 1'b1;
    endtask

    task automatic do_reset();
        next(); rst = 1'b1;
        next(); rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1; stall_req = 4'b0; load_hazard = 1'b0; flush_req = 5'b0;
        if_pc = 12'h000; id_pc = 12'h004; is_jump = 1'b0; wb_wr_en = 1'b1;

        // Reset state
        next(); rst = 1'b1; stall_req = 4'b0001;
        exp_sig("rst_stall",  S_STALL, 5'b00000);
        exp_sig("rst_flush",  S_FLUSH, 5'b11111);
        exp_sig("rst_clk_en", S_CLKEN, 5'b11111);
        exp_sig("rst_rf",     S_RF,    5'b00000);
        exp_sig("rst_to",     S_TO,    5'b00000);
        next();
        exp_sig("idle_stall",  S_STALL, 5'b00000);
        exp_sig("idle_flush",  S_FLUSH, 5'b00000);
        exp_sig("idle_clk_en", S_CLKEN, 5'b11111);
        exp_sig("idle_bubble", S_BUB,   5'b00000);
        exp_sig("idle_rf",     S_RF,    5'b00001);

        // Single-cycle load-use stall (LOAD_LAT=1)
        next(); load_hazard = 1'b1;
        exp_sig("ld1_stall",  S_STALL, 5'b00111);
        exp_sig("ld1_flush",  S_FLUSH, 5'b01000);
        exp_sig("ld1_clk_en", S_CLKEN, 5'b11000);
        exp_sig("ld1_lsa",    S_LSA,   5'b00001);
        next(); load_hazard = 1'b1;   // producer is now a bubble: ignored
        exp_sig("ld1b_bubble", S_BUB,   5'b01000);
        exp_sig("ld1b_stall",  S_STALL, 5'b00000);
        exp_sig("ld1b_lsa",    S_LSA,   5'b00000);
        exp_sig("ld1b_clk_en", S_CLKEN, 5'b01111);
        exp_sig("ld1b_rf",     S_RF,    5'b00001);
        next();
        exp_sig("ld1c_bubble", S_BUB,   5'b10000);
        exp_sig("ld1c_rf",     S_RF,    5'b00000);
        exp_sig("ld1c_clk_en", S_CLKEN, 5'b11111);
        next();
        exp_sig("ld1d_rf",     S_RF,    5'b00001);

        // Three-cycle load stall, second hazard mid-count ignored
        do_reset();
        next(); load_hazard = 1'b1;
        exp_sig("ld3_c1_stall", S_STALL3, 5'b00111);
        exp_sig("ld3_c1_lsa",   S_LSA3,   5'b00001);
        next();
        exp_sig("ld3_c2_stall", S_STALL3, 5'b00111);
        next(); load_hazard = 1'b1;
        exp_sig("ld3_c3_stall", S_STALL3, 5'b00111);
        exp_sig("ld3_c3_lsa",   S_LSA3,   5'b00001);
        next();
        exp_sig("ld3_c4_stall", S_STALL3, 5'b00000);
        exp_sig("ld3_c4_lsa",   S_LSA3,   5'b00000);
        next();
        exp_sig("ld3_c5_lsa",   S_LSA3,   5'b00000);

        // Depth-2 source held 4 cycles over a pre-existing bubble in reg 1
        do_reset();
        next(); flush_req = 5'b00010;
        exp_sig("pre_flush", S_FLUSH, 5'b00010);
        next(); stall_req = 4'b0100;
        exp_sig("d2_q1_stall",  S_STALL, 5'b00011);
        exp_sig("d2_q1_flush",  S_FLUSH, 5'b00100);
        exp_sig("d2_q1_bubble", S_BUB,   5'b00010);
        exp_sig("d2_q1_clk_en", S_CLKEN, 5'b11100);
        next(); stall_req = 4'b0100;
        exp_sig("d2_q2_flush",  S_FLUSH, 5'b00100);
        exp_sig("d2_q2_bubble", S_BUB,   5'b00110);
        exp_sig("d2_q2_clk_en", S_CLKEN, 5'b10100);
        next(); stall_req = 4'b0100;
        exp_sig("d2_q3_bubble", S_BUB,   5'b01110);
        exp_sig("d2_q3_clk_en", S_CLKEN, 5'b00100);
        next(); stall_req = 4'b0100;
        exp_sig("d2_q4_stall",  S_STALL, 5'b00011);
        exp_sig("d2_q4_bubble", S_BUB,   5'b11110);
        exp_sig("d2_q4_rf",     S_RF,    5'b00000);
        next();
        exp_sig("d2_rel_stall",  S_STALL, 5'b00000);
        exp_sig("d2_rel_clk_en", S_CLKEN, 5'b00011);

        // Self-loop jump
        do_reset();
        next(); if_pc = 12'h040; id_pc = 12'h040; is_jump = 1'b1;
        exp_sig("loop_clk_en", S_CLKEN, 5'b11100);
        exp_sig("loop_flush",  S_FLUSH, 5'b00010);
        next();
        exp_sig("loop2_bubble", S_BUB,   5'b00010);
        exp_sig("loop2_clk_en", S_CLKEN, 5'b11011);
        // Loop gating suppressed while ID is stalled
        do_reset();
        next(); if_pc = 12'h040; id_pc = 12'h040; is_jump = 1'b1; stall_req = 4'b0001;
        exp_sig("loopst_flush", S_FLUSH, 5'b01000);
        exp_sig("loopst_stall", S_STALL, 5'b00111);

        // Flush inside a stalled region, then reset mid-stall
        do_reset();
        next(); flush_req = 5'b00010; stall_req = 4'b0001; load_hazard = 1'b1;
        exp_sig("fs1_stall",  S_STALL, 5'b00111);
        exp_sig("fs1_flush",  S_FLUSH, 5'b01010);
        exp_sig("fs1_clk_en", S_CLKEN, 5'b11000);
        next(); stall_req = 4'b0001;
        exp_sig("fs2_bubble", S_BUB,   5'b01010);
        exp_sig("fs2_stall",  S_STALL, 5'b00111);
        exp_sig("fs2_lsa3",   S_LSA3,  5'b00001);
        next(); rst = 1'b1; stall_req = 4'b0001;
        exp_sig("fs_rst_stall", S_STALL, 5'b00000);
        exp_sig("fs_rst_flush", S_FLUSH, 5'b11111);
        next();
        exp_sig("fs_post_bubble", S_BUB,  5'b00000);
        exp_sig("fs_post_lsa3",   S_LSA3, 5'b00000);

        // Stall watchdog
        do_reset();
`ifdef STALL_WDOG_EN
        for (int c = 0; c < 16; c++) begin
            next(); stall_req = 4'b0001;
            if (c == 14) exp_sig("wdog_c14", S_TO, 5'b00000);
            if (c == 15) exp_sig("wdog_c15", S_TO, 5'b00001);
        end
        next();
        exp_sig("wdog_sticky1", S_TO, 5'b00001);
        next();
        exp_sig("wdog_sticky2", S_TO, 5'b00001);
        next(); rst = 1'b1;
        exp_sig("wdog_rst", S_TO, 5'b00000);
        next();
        exp_sig("wdog_after_rst", S_TO, 5'b00000);
`else
        for (int c = 0; c < 20; c++) begin
            next(); stall_req = 4'b0001;
        end
        exp_sig("no_wdog", S_TO, 5'b00000);
`endif

        next();
        next();
        checks++;
        if (q_sig.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q_sig.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
